// File: rtl/axi_lite_host_seq.sv
// axi_lite_host_seq
//
// Runs one accelerator job over an AXI-Lite master port: write K (0x08),
// write CTRL.start (0x00 <= 1), then poll STATUS (0x04) until done (bit 0),
// inserting POLL_GAP idle cycles between polls. The job outcome is returned
// on a valid/ready response channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_k  job request; accepted only while idle
//   rsp_valid/rsp_ready        job completion handshake
//   rsp_status                 00 ok, 01 write error, 10 read error, 11 timeout
//   m_axi_aw*/w*/b*            AXI-Lite write channels
//   m_axi_ar*/r*               AXI-Lite read channels
//
// Optional feature: define HOST_SEQ_TIMEOUT_EN to give up after 256 STATUS
// reads that return done=0 (status 11). Without it, polling never stops.

module axi_lite_host_seq #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int POLL_GAP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_k,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic              m_axi_bvalid,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WR_K    = 4'd1;
    localparam logic [3:0] ST_WR_K_B  = 4'd2;
    localparam logic [3:0] ST_WR_GO   = 4'd3;
    localparam logic [3:0] ST_WR_GO_B = 4'd4;
    localparam logic [3:0] ST_RD_ST   = 4'd5;
    localparam logic [3:0] ST_RD_ST_R = 4'd6;
    localparam logic [3:0] ST_GAP     = 4'd7;
    localparam logic [3:0] ST_RSP     = 4'd8;

    localparam logic [ADDR_W-1:0] REG_CTRL   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] REG_STATUS = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] REG_K      = ADDR_W'(8'h08);

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_WR_ERR  = 2'b01;
    localparam logic [1:0] RSP_RD_ERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    // Gap counter runs 0 .. POLL_GAP-1; keep at least one bit so POLL_GAP=0 still elaborates.
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    logic [3:0]        state_r;
    logic              cmd_ready_r;
    logic              awvalid_r;
    logic              wvalid_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              bready_r;
    logic              arvalid_r;
    logic [ADDR_W-1:0] araddr_r;
    logic              rready_r;
    logic              rsp_valid_r;
    logic [1:0]        rsp_status_r;
    logic [GAP_W-1:0]  gap_cnt_r;

    logic aw_done_s;
    logic w_done_s;
    logic timeout_s;
    logic unused_s;

    // A channel is finished once its valid has dropped or is handshaking right now.
    assign aw_done_s = !awvalid_r || m_axi_awready;
    assign w_done_s  = !wvalid_r  || m_axi_wready;

    // Only bit 0 of STATUS and the upper response bit carry meaning here.
    assign unused_s = ^{m_axi_rdata[DATA_W-1:1], m_axi_bresp[0], m_axi_rresp[0]};

`ifdef HOST_SEQ_TIMEOUT_EN
    logic [7:0] poll_cnt_r;

    // Counts not-done STATUS reads since polling for the current job began.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_r <= 8'd0;
        end else if (state_r == ST_WR_GO_B && m_axi_bvalid && !m_axi_bresp[1]) begin
            poll_cnt_r <= 8'd0;
        end else if (state_r == ST_RD_ST_R && m_axi_rvalid && !m_axi_rresp[1] && !m_axi_rdata[0]) begin
            poll_cnt_r <= poll_cnt_r + 8'd1;
        end else begin
            poll_cnt_r <= poll_cnt_r;
        end
    end

    // The 256th not-done read arrives while 255 are already counted.
    assign timeout_s = (poll_cnt_r == 8'd255);
`else
    assign timeout_s = 1'b0;
`endif

    // Sequencer FSM; every AXI and response output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b1;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            awaddr_r     <= '0;
            wdata_r      <= '0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            araddr_r     <= '0;
            rready_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= RSP_OK;
            gap_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        state_r     <= ST_WR_K;
                        cmd_ready_r <= 1'b0;
                        awvalid_r   <= 1'b1;
                        wvalid_r    <= 1'b1;
                        awaddr_r    <= REG_K;
                        wdata_r     <= DATA_W'(cmd_k);
                    end
                end
                ST_WR_K, ST_WR_GO: begin
                    // AW and W complete independently; move on when both are done.
                    if (awvalid_r && m_axi_awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && m_axi_wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        state_r  <= (state_r == ST_WR_K) ? ST_WR_K_B : ST_WR_GO_B;
                        bready_r <= 1'b1;
                    end
                end
                ST_WR_K_B, ST_WR_GO_B: begin
                    if (m_axi_bvalid) begin
                        bready_r <= 1'b0;
                        if (m_axi_bresp[1]) begin
                            state_r      <= ST_RSP;
                            rsp_valid_r  <= 1'b1;
                            rsp_status_r <= RSP_WR_ERR;
                        end else if (state_r == ST_WR_K_B) begin
                            state_r   <= ST_WR_GO;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            awaddr_r  <= REG_CTRL;
                            wdata_r   <= DATA_W'(32'd1);
                        end else begin
                            state_r   <= ST_RD_ST;
                            arvalid_r <= 1'b1;
                            araddr_r  <= REG_STATUS;
                        end
                    end
                end
                ST_RD_ST: begin
                    if (m_axi_arready) begin
                        state_r   <= ST_RD_ST_R;
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                    end
                end
                ST_RD_ST_R: begin
                    if (m_axi_rvalid) begin
                        rready_r <= 1'b0;
                        if (m_axi_rresp[1]) begin
                            state_r      <= ST_RSP;
                            rsp_valid_r  <= 1'b1;
                            rsp_status_r <= RSP_RD_ERR;
                        end else if (m_axi_rdata[0]) begin
                            state_r      <= ST_RSP;
                            rsp_valid_r  <= 1'b1;
                            rsp_status_r <= RSP_OK;
                        end else if (timeout_s) begin
                            state_r      <= ST_RSP;
                            rsp_valid_r  <= 1'b1;
                            rsp_status_r <= RSP_TIMEOUT;
                        end else if (POLL_GAP == 0) begin
                            state_r   <= ST_RD_ST;
                            arvalid_r <= 1'b1;
                        end else begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r   <= ST_RD_ST;
                        arvalid_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: drop everything and go idle.
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_status    = rsp_status_r;
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_host_seq.sv
// Directed testbench for axi_lite_host_seq: a small AXI-Lite slave model
// with configurable AW delay, K-write error, read error and done-on-Nth-read,
// plus a linear sequence of jobs checked with immediate assertions.

module tb_axi_lite_host_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_k;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic        m_axi_bvalid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi_lite_host_seq #(.ADDR_W(32), .DATA_W(32), .POLL_GAP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave knobs (written by the stimulus block only)
    int aw_delay = 0;
    int done_on  = 0;
    bit k_err    = 1'b0;
    bit r_err    = 1'b0;

    // Slave state and cumulative logs (written by the slave block only)
    int wr_n = 0, b_n = 0, rd_n = 0, rd_job = 0, bad_ar = 0;
    int aw_wait = 0, aw_hi_run = 0, w_hi_run = 0;
    int rd_cyc_last = 0, rd_cyc_prev = 0;
    bit aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, b_err_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] aw_addr_c = 32'h0, w_data_c = 32'h0;
    int wr_addr_log [0:63];
    int wr_data_log [0:63];
    int aw_hi_log   [0:63];
    int w_hi_log    [0:63];
    int go_b_log    [0:63];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // AXI-Lite slave model: decides readies/responses at each falling edge.
    initial begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
                b_pend = 1'b0; r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                aw_wait = 0; aw_hi_run = 0; w_hi_run = 0;
            end else begin
                if (b_pend) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = b_err_pend ? 2'b10 : 2'b00;
                    if (m_axi_bready) begin b_pend = 1'b0; b_n++; end
                end else begin
                    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                end
                if (r_pend) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rresp  = (r_err && rd_job == 1) ? 2'b10 : 2'b00;
                    m_axi_rdata  = (rd_job == done_on) ? 32'h0000_0001 : 32'hFFFF_FFFE;
                    if (m_axi_rready) r_pend = 1'b0;
                end else begin
                    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
                end
                if (m_axi_awvalid) aw_hi_run++;
                if (m_axi_wvalid)  w_hi_run++;
                if (m_axi_awvalid && !aw_got) begin
                    if (aw_wait == aw_delay) begin
                        m_axi_awready = 1'b1; aw_got = 1'b1; aw_addr_c = m_axi_awaddr; aw_wait = 0;
                    end else begin
                        m_axi_awready = 1'b0; aw_wait++;
                    end
                end else begin
                    m_axi_awready = 1'b0;
                end
                if (m_axi_wvalid && !w_got) begin
                    m_axi_wready = 1'b1; w_got = 1'b1; w_data_c = m_axi_wdata;
                end else begin
                    m_axi_wready = 1'b0;
                end
                if (aw_got && w_got && wr_n < 64) begin
                    wr_addr_log[wr_n] = int'(aw_addr_c);
                    wr_data_log[wr_n] = int'(w_data_c);
                    aw_hi_log[wr_n]   = aw_hi_run;
                    w_hi_log[wr_n]    = w_hi_run;
                    go_b_log[wr_n]    = b_n;
                    b_pend     = 1'b1;
                    b_err_pend = k_err && (aw_addr_c == 32'h8);
                    if (aw_addr_c == 32'h0) rd_job = 0;
                    wr_n++;
                    aw_got = 1'b0; w_got = 1'b0; aw_hi_run = 0; w_hi_run = 0;
                end
                if (m_axi_arvalid) begin
                    m_axi_arready = 1'b1;
                    if (m_axi_araddr != 32'h4) bad_ar++;
                    rd_n++; rd_job++; r_pend = 1'b1;
                    rd_cyc_prev = rd_cyc_last; rd_cyc_last = cyc;
                end else begin
                    m_axi_arready = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input string tag, input logic [31:0] k);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_k     = k;
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_busy"}, int'(cmd_ready), 0);
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        int n = 0;
        while (!rsp_valid && n < max_cyc) begin tick(); n++; end
        chk({tag, "_rsp_seen"}, int'(rsp_valid), 1);
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, int'(rsp_valid), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, int'(m_axi_awvalid), 0);
        chk({tag, "_wvalid"},  int'(m_axi_wvalid), 0);
        chk({tag, "_bready"},  int'(m_axi_bready), 0);
        chk({tag, "_arvalid"}, int'(m_axi_arvalid), 0);
        chk({tag, "_rready"},  int'(m_axi_rready), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_status"}, int'(rsp_status), 0);
        chk({tag, "_awaddr"},  int'(m_axi_awaddr), 0);
        chk({tag, "_wdata"},   int'(m_axi_wdata), 0);
        chk({tag, "_araddr"},  int'(m_axi_araddr), 0);
    endtask

    initial begin
        int bw, bb, br, n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_k = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("reset_cmd_ready", int'(cmd_ready), 1);

        // K=5, done on third STATUS read
        bw = wr_n; bb = b_n; br = rd_n; done_on = 3;
        start_job("basic", 32'd5);
        wait_rsp("basic", 200);
        chk("basic_status", int'(rsp_status), 0);
        chk("basic_writes", wr_n - bw, 2);
        chk("basic_k_addr", wr_addr_log[bw], 32'h8);
        chk("basic_k_data", wr_data_log[bw], 32'd5);
        chk("basic_go_addr", wr_addr_log[bw + 1], 32'h0);
        chk("basic_go_data", wr_data_log[bw + 1], 32'd1);
        chk("basic_bresp_cnt", b_n - bb, 2);
        chk("basic_reads", rd_n - br, 3);
        chk("basic_araddr", bad_ar, 0);
        chk("basic_poll_spacing", rd_cyc_last - rd_cyc_prev, 6);
        take_rsp("basic");

        // Read error on first STATUS read
        br = rd_n; done_on = 0; r_err = 1'b1;
        start_job("rderr", 32'h1234_5678);
        wait_rsp("rderr", 200);
        chk("rderr_status", int'(rsp_status), 2);
        chk("rderr_reads", rd_n - br, 1);
        take_rsp("rderr");
        r_err = 1'b0;

        // awready delayed 3 cycles, wready immediate
        bw = wr_n; bb = b_n; done_on = 1; aw_delay = 3;
        start_job("awdly", 32'hA5);
        wait_rsp("awdly", 200);
        chk("awdly_status", int'(rsp_status), 0);
        chk("awdly_aw_cycles", aw_hi_log[bw], 4);
        chk("awdly_w_cycles", w_hi_log[bw], 1);
        chk("awdly_b_before_go", go_b_log[bw + 1] - bb, 1);
        chk("awdly_go_addr", wr_addr_log[bw + 1], 32'h0);
        take_rsp("awdly");
        aw_delay = 0;

        // Error response on K write: no CTRL write follows
        bw = wr_n; bb = b_n; br = rd_n; k_err = 1'b1;
        start_job("kerr", 32'd9);
        wait_rsp("kerr", 200);
        chk("kerr_status", int'(rsp_status), 1);
        chk("kerr_writes", wr_n - bw, 1);
        chk("kerr_bresp_cnt", b_n - bb, 1);
        chk("kerr_reads", rd_n - br, 0);
        take_rsp("kerr");
        k_err = 1'b0;

        // Response held while rsp_ready is low
        done_on = 1;
        start_job("hold", 32'd3);
        wait_rsp("hold", 200);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_status", int'(rsp_status), 0);
        end
        take_rsp("hold");

        // Reset pulsed while the CTRL write is in flight
        start_job("rstgo", 32'd7);
        n = 0;
        while (!(m_axi_awvalid && m_axi_awaddr == 32'h0) && n < 50) begin tick(); n++; end
        chk("rstgo_reached", int'(m_axi_awvalid && m_axi_awaddr == 32'h0), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rstgo_in_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        br = rd_n;
        repeat (10) tick();
        chk("rstgo_cmd_ready", int'(cmd_ready), 1);
        chk("rstgo_no_rsp", int'(rsp_valid), 0);
        chk("rstgo_no_reads", rd_n - br, 0);
        chk("rstgo_awvalid", int'(m_axi_awvalid), 0);

        // Done never set
        br = rd_n; done_on = 0;
        start_job("poll", 32'd11);
`ifdef HOST_SEQ_TIMEOUT_EN
        wait_rsp("poll", 2500);
        chk("poll_status", int'(rsp_status), 3);
        chk("poll_reads", rd_n - br, 256);
        chk("poll_spacing", rd_cyc_last - rd_cyc_prev, 6);
        take_rsp("poll");
`else
        n = 0;
        while ((rd_n - br) < 300 && n < 2500) begin tick(); n++; end
        chk("poll_reads_continue", int'((rd_n - br) >= 300), 1);
        chk("poll_no_rsp", int'(rsp_valid), 0);
        chk("poll_spacing", rd_cyc_last - rd_cyc_prev, 6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("poll_abandon_cmd_ready", int'(cmd_ready), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_host_seq.md
AXI_LITE_HOST_SEQ -- requirements
Module: axi_lite_host_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter POLL_GAP, default 4, idle cycles between successive STATUS reads (0 legal).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  job request.
REQ-007 SHALL have port cmd_ready  out  1  sequencer idle, accepts job.
REQ-008 SHALL have port cmd_k  in  32  K value for the job.
REQ-009 SHALL have port rsp_valid  out  1  job finished.
REQ-010 SHALL have port rsp_ready  in  1  response consumed.
REQ-011 SHALL have port rsp_status  out  2  00 OK, 01 write SLVERR/DECERR, 10 read SLVERR/DECERR, 11 timeout.
REQ-012 SHALL have port m_axi_awaddr  out  ADDR_W  write address.
REQ-013 SHALL have port m_axi_awvalid  out  1  write address valid.
REQ-014 SHALL have port m_axi_awready  in  1  write address ready.
REQ-015 SHALL have port m_axi_wdata  out  DATA_W  write data.
REQ-016 SHALL have port m_axi_wvalid  out  1  write data valid.
REQ-017 SHALL have port m_axi_wready  in  1  write data ready.
REQ-018 SHALL have port m_axi_bvalid  in  1  write response valid.
REQ-019 SHALL have port m_axi_bresp  in  2  write response code.
REQ-020 SHALL have port m_axi_bready  out  1  write response ready.
REQ-021 SHALL have port m_axi_araddr  out  ADDR_W  read address.
REQ-022 SHALL have port m_axi_arvalid  out  1  read address valid.
REQ-023 SHALL have port m_axi_arready  in  1  read address ready.
REQ-024 SHALL have port m_axi_rdata  in  DATA_W  read data.
REQ-025 SHALL have port m_axi_rresp  in  2  read response code.
REQ-026 SHALL have port m_axi_rvalid  in  1  read data valid.
REQ-027 SHALL have port m_axi_rready  out  1  read data ready.

Function
REQ-028 Register map SHALL be: 0x00 CTRL (bit0 start, write-1), 0x04 STATUS (bit0 done), 0x08 K.
REQ-029 FSM SHALL be IDLE -> WR_K -> WR_K_B -> WR_GO -> WR_GO_B -> RD_ST -> RD_ST_R -> (GAP -> RD_ST | RSP) -> IDLE.
REQ-030 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready captures cmd_k and enters WR_K next cycle.
REQ-031 WR_K/WR_GO SHALL assert awvalid and wvalid together (awaddr 0x08/wdata=K, then awaddr 0x00/wdata=1); each valid drops the cycle after its own handshake, and the state advances once both have completed, in either order or the same cycle.
REQ-032 Valids SHALL stay asserted with address/data stable until handshake; no valid depends on a ready.
REQ-033 *_B states SHALL assert bready; on bvalid, bresp[1]=1 SHALL go to RSP with status 01, otherwise advance.
REQ-034 RD_ST SHALL assert arvalid, araddr 0x04, until arready; RD_ST_R asserts rready until rvalid.
REQ-035 On rvalid: rresp[1]=1 -> RSP status 10; rdata[0]=1 -> RSP status 00; otherwise GAP for exactly POLL_GAP cycles (skipped if 0), then RD_ST.
REQ-036 RSP SHALL hold rsp_valid=1 and rsp_status stable until rsp_ready, then return to IDLE; back-to-back jobs are legal.
REQ-037 bready/rready SHALL be 0 outside their states; stray bvalid/rvalid SHALL be ignored.

Reset
REQ-038 On rst_n low, FSM SHALL go to IDLE at once and all valids, bready, rready, rsp_valid SHALL be 0, addresses/wdata 0, rsp_status 00, cmd_ready 1 after release.
REQ-039 Reset mid-transaction SHALL abandon the job with no response.

Configuration
REQ-040 With HOST_SEQ_TIMEOUT_EN defined, a poll counter SHALL clear on entering RD_ST from WR_GO_B, count each STATUS read returning done=0, and after 256 such reads enter RSP with status 11.
REQ-041 Without HOST_SEQ_TIMEOUT_EN, polling SHALL continue indefinitely and status 11 SHALL never occur.

Verification
REQ-042 K=5, slave always ready, done on 3rd read -> writes 0x08=5 then 0x00=1, three reads of 0x04, rsp_status 00.
REQ-043 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 4, one B handshake, then WR_GO.
REQ-044 bresp=10 on K write -> no CTRL write, rsp_status 01.
REQ-045 POLL_GAP=4, done never set, macro defined -> 256 reads spaced by 4 idle cycles, rsp_status 11; macro undefined -> reads continue.
REQ-046 rsp_ready held low 10 cycles, rst_n pulsed during WR_GO -> rsp stable while held; after reset all outputs zero, cmd_ready 1.
